// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative unsigned multiply/divide unit that sits beside the register file.
//   Operands arrive from the two read ports. The result goes back through the
//   write port. The unit is radix-2 and resolves one bit per clock. Every
//   operation takes the same fixed latency, and the core stalls while busy is
//   high.
//
//   op encoding: 00 MUL (low word), 01 MULHU (high word),
//                10 DIVU (quotient), 11 REMU (remainder)
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        request, sampled only in IDLE
//   op           operation select
//   operand_a    multiplicand / dividend
//   operand_b    multiplier / divisor
//   dest_reg     destination register address
//   busy         high in CALC and DONE
//   done         one-cycle completion strobe
//   reg_write    register-file write enable (equals done)
//   write_reg    captured destination register (held until next start)
//   write_data   result (held until next start)
//   div_by_zero  DIVU/REMU with operand_b == 0 (held until next start)
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                op,
  input  logic [DATA_WIDTH-1:0]     operand_a,
  input  logic [DATA_WIDTH-1:0]     operand_b,
  input  logic [REG_ADDR_WIDTH-1:0] dest_reg,
  output logic                      busy,
  output logic                      done,
  output logic                      reg_write,
  output logic [REG_ADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]     write_data,
  output logic                      div_by_zero
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OP_MUL   = 2'b00,
    OP_MULHU = 2'b01,
    OP_DIVU  = 2'b10,
    OP_REMU  = 2'b11
  } op_e;

  // ---------------------------------------------------------------------------
  // Control: state register and iteration counter
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;     // start taken this edge
  logic             last_iter;  // this edge performs the final iteration

  assign accept    = (state_q == S_IDLE) && start;
  assign last_iter = (state_q == S_CALC) && (cnt_q == CNT_LAST);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first. Otherwise a path
  // that does not assign it would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_CALC;
      end
      S_CALC: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q == S_CALC) || (state_q == S_DONE);
  assign done      = (state_q == S_DONE);
  assign reg_write = done;

  // ---------------------------------------------------------------------------
  // Datapath working registers
  // ---------------------------------------------------------------------------
  op_e                       op_q;
  logic [DATA_WIDTH-1:0]     a_q;     // multiplicand, held for MUL/MULHU
  logic [DATA_WIDTH-1:0]     b_q;     // divisor, held for DIVU/REMU
  logic [REG_ADDR_WIDTH-1:0] dest_q;
  logic [2*DATA_WIDTH-1:0]   acc_q;   // {product high, multiplier/product low}
  logic [DATA_WIDTH-1:0]     quo_q;   // dividend shifting out, quotient in
  logic [DATA_WIDTH-1:0]     rem_q;   // partial remainder

  // Shift-add multiply. The multiplier sits in the low half of the
  // accumulator. Each step adds the multiplicand into the high half when the
  // multiplier LSB is set, then shifts right by one. The carry of the add
  // lands in the top bit.
  logic [DATA_WIDTH:0]     mul_sum;
  logic [2*DATA_WIDTH-1:0] acc_next;

  assign mul_sum  = {1'b0, acc_q[2*DATA_WIDTH-1:DATA_WIDTH]}
                  + {1'b0, (acc_q[0] ? a_q : {DATA_WIDTH{1'b0}})};
  assign acc_next = {mul_sum, acc_q[DATA_WIDTH-1:1]};

  // Restoring divide. The (DATA_WIDTH+1)-bit shifted remainder is compared
  // against the divisor. The quotient bit is set when the subtraction does not
  // borrow. The kept remainder is always below the divisor, so DATA_WIDTH bits
  // of it hold the full value. With a zero divisor every step succeeds. That
  // leaves an all-ones quotient and the dividend as the remainder.
  logic [DATA_WIDTH:0]   rem_shift;
  logic                  no_borrow;
  logic [DATA_WIDTH-1:0] rem_diff;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] quo_next;

  assign rem_shift = {rem_q, quo_q[DATA_WIDTH-1]};
  assign no_borrow = (rem_shift >= {1'b0, b_q});
  assign rem_diff  = rem_shift[DATA_WIDTH-1:0] - b_q;
  assign rem_next  = no_borrow ? rem_diff : rem_shift[DATA_WIDTH-1:0];
  assign quo_next  = {quo_q[DATA_WIDTH-2:0], no_borrow};

  // NOTE: the working registers carry no reset. They are always loaded on an
  // accepted start before they are used, and the outputs come from separately
  // reset registers.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q   <= op_e'(op);
      a_q    <= operand_a;
      b_q    <= operand_b;
      dest_q <= dest_reg;
      acc_q  <= {{DATA_WIDTH{1'b0}}, operand_b};
      quo_q  <= operand_a;
      rem_q  <= '0;
    end else if (state_q == S_CALC) begin
      acc_q <= acc_next;
      quo_q <= quo_next;
      rem_q <= rem_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Result selection and output registers
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] result;

  always_comb begin
    result = '0;
    unique case (op_q)
      OP_MUL:   result = acc_next[DATA_WIDTH-1:0];
      OP_MULHU: result = acc_next[2*DATA_WIDTH-1:DATA_WIDTH];
      OP_DIVU:  result = quo_next;
      OP_REMU:  result = rem_next;
      default:  result = '0;
    endcase
  end

  logic [DATA_WIDTH-1:0]     write_data_q, write_data_d;
  logic [REG_ADDR_WIDTH-1:0] write_reg_q,  write_reg_d;
  logic                      dbz_q,        dbz_d;

  // The outputs are loaded on the edge that performs the last iteration, so
  // they are valid throughout DONE. They hold until the next accepted start
  // clears them.
  always_comb begin
    write_data_d = write_data_q;
    write_reg_d  = write_reg_q;
    dbz_d        = dbz_q;
    if (accept) begin
      write_data_d = '0;
      write_reg_d  = '0;
      dbz_d        = 1'b0;
    end else if (last_iter) begin
      write_data_d = result;
      write_reg_d  = dest_q;
      dbz_d        = op_q[1] && (b_q == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      write_data_q <= '0;
      write_reg_q  <= '0;
      dbz_q        <= 1'b0;
    end else begin
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
      dbz_q        <= dbz_d;
    end
  end

  assign write_data  = write_data_q;
  assign write_reg   = write_reg_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit. Expected results come from a
//   behavioural model and are queued at issue. They are popped and compared
//   when the unit raises done. Inputs change on the falling edge, and outputs
//   are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int DW = 32;
  localparam int AW = 3;
  localparam int LATENCY = DW + 1;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    op;
  logic [DW-1:0] operand_a;
  logic [DW-1:0] operand_b;
  logic [AW-1:0] dest_reg;
  logic          busy;
  logic          done;
  logic          reg_write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
  logic          div_by_zero;

  muldiv_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .dest_reg    (dest_reg),
    .busy        (busy),
    .done        (done),
    .reg_write   (reg_write),
    .write_reg   (write_reg),
    .write_data  (write_data),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [AW-1:0] wreg;
    logic          dbz;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model uses native wide arithmetic.
  function automatic exp_t model(input logic [1:0] o, input logic [DW-1:0] a,
                                 input logic [DW-1:0] b, input logic [AW-1:0] d);
    exp_t          e;
    logic [63:0]   p;
    p      = {32'b0, a} * {32'b0, b};
    e.wreg = d;
    e.dbz  = o[1] && (b == 0);
    case (o)
      2'b00:   e.data = p[31:0];
      2'b01:   e.data = p[63:32];
      2'b10:   e.data = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: e.data = (b == 0) ? a : a % b;
    endcase
    return e;
  endfunction

  // Issue one operation from a falling edge in IDLE and wait for the result.
  // The task returns on the falling edge of the first IDLE cycle after DONE.
  task automatic do_op(input logic [1:0] o, input logic [DW-1:0] a,
                       input logic [DW-1:0] b, input logic [AW-1:0] d);
    exp_t e;
    int   n;
    logic busy_drop;
    sb.push_back(model(o, a, b, d));
    start = 1'b1; op = o; operand_a = a; operand_b = b; dest_reg = d;
    @(negedge clk);
    start = 1'b0;
    operand_a = $urandom; operand_b = $urandom; op = 2'($urandom); dest_reg = 3'($urandom);
    total++;
    if (busy !== 1'b1 || write_data !== '0 || write_reg !== '0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL accept op=%0d: busy=%b wd=%h wr=%0d dbz=%b, want busy=1 and outputs cleared",
               o, busy, write_data, write_reg, div_by_zero);
    end
    n = 1;
    busy_drop = 1'b0;
    while (done !== 1'b1 && n < LATENCY + 8) begin
      @(negedge clk);
      n++;
      if (busy !== 1'b1) busy_drop = 1'b1;
    end
    total++;
    if (busy_drop) begin
      bad++;
      $display("FAIL busy_hold op=%0d: busy fell before done", o);
    end
    e = sb.pop_front();
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL timeout op=%0d: no done within %0d cycles", o, n);
      return;
    end
    if (n != LATENCY) begin
      bad++;
      $display("FAIL latency op=%0d: got %0d, want %0d", o, n, LATENCY);
    end
    total++;
    if (write_data !== e.data) begin
      bad++;
      $display("FAIL data op=%0d a=%h b=%h: got %h, want %h", o, a, b, write_data, e.data);
    end
    total++;
    if (write_reg !== e.wreg || reg_write !== 1'b1) begin
      bad++;
      $display("FAIL wreg op=%0d: got reg=%0d we=%b, want reg=%0d we=1",
               o, write_reg, reg_write, e.wreg);
    end
    total++;
    if (div_by_zero !== e.dbz) begin
      bad++;
      $display("FAIL dbz op=%0d b=%h: got %b, want %b", o, b, div_by_zero, e.dbz);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || reg_write !== 1'b0 || busy !== 1'b0 || write_data !== e.data) begin
      bad++;
      $display("FAIL after_done op=%0d: done=%b we=%b busy=%b wd=%h, want 0/0/0/%h",
               o, done, reg_write, busy, write_data, e.data);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; op = 2'b00; operand_a = 32'd7; operand_b = 32'd6; dest_reg = 3'd3;
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || reg_write !== 1'b0 || write_data !== '0 ||
        write_reg !== '0 || div_by_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: busy=%b done=%b we=%b wd=%h wr=%0d dbz=%b, want all 0",
               busy, done, reg_write, write_data, write_reg, div_by_zero);
    end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_start_ignored: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_mul();
    do_op(2'b00, 32'd7, 32'd6, 3'd3);
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1);
    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2);
    do_op(2'b01, 32'h8000_0001, 32'h0001_0003, 3'd4);
  endtask

  task automatic test_div();
    do_op(2'b10, 32'd100, 32'd7, 3'd4);
    do_op(2'b11, 32'd100, 32'd7, 3'd5);
    do_op(2'b10, 32'hFFFF_FFFF, 32'd1, 3'd6);
    do_op(2'b11, 32'd3, 32'hFFFF_FFFF, 3'd7);
  endtask

  task automatic test_div_zero();
    do_op(2'b00, 32'd123, 32'd0, 3'd2);
    do_op(2'b10, 32'd5, 32'd0, 3'd6);
    do_op(2'b11, 32'd5, 32'd0, 3'd7);
    repeat (3) @(negedge clk);
    total++;
    if (write_data !== 32'd5 || write_reg !== 3'd7 || div_by_zero !== 1'b1) begin
      bad++;
      $display("FAIL hold: wd=%h wr=%0d dbz=%b, want 5/7/1", write_data, write_reg, div_by_zero);
    end
  endtask

  task automatic test_dest_zero();
    do_op(2'b00, 32'h1234_5678, 32'h10, 3'd0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      logic [1:0]    o;
      logic [DW-1:0] a, b;
      o = 2'(i);
      a = $urandom;
      b = (i == 4) ? 32'($urandom_range(1, 255)) : $urandom;
      do_op(o[1:0], a, b, 3'(i + 1));
    end
  endtask

  task automatic test_ignored_start();
    exp_t e;
    int   n;
    int   extra;
    sb.push_back(model(2'b00, 32'd3, 32'd4, 3'd2));
    start = 1'b1; op = 2'b00; operand_a = 32'd3; operand_b = 32'd4; dest_reg = 3'd2;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < LATENCY + 8) begin
      @(negedge clk);
      n++;
      if (n == 6) begin
        start = 1'b1; op = 2'b10; operand_a = 32'd9; operand_b = 32'd3; dest_reg = 3'd5;
      end else begin
        start = 1'b0;
      end
    end
    e = sb.pop_front();
    total++;
    if (done !== 1'b1 || n != LATENCY || write_data !== e.data || write_reg !== e.wreg) begin
      bad++;
      $display("FAIL ignored_start: done=%b n=%0d wd=%h wr=%0d, want 1/%0d/%h/%0d",
               done, n, write_data, write_reg, LATENCY, e.data, e.wreg);
    end
    // A start held during DONE must be dropped as well.
    start = 1'b1; op = 2'b10; operand_a = 32'd9; operand_b = 32'd3; dest_reg = 3'd5;
    @(negedge clk);
    start = 1'b0;
    extra = 0;
    for (int i = 0; i < LATENCY + 8; i++) begin
      if (done === 1'b1 || busy === 1'b1) extra++;
      @(negedge clk);
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL no_second_done: busy/done seen %0d cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_midcalc();
    int writes;
    start = 1'b1; op = 2'b00; operand_a = 32'd5; operand_b = 32'd5; dest_reg = 3'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || reg_write !== 1'b0 || write_data !== '0) begin
      bad++;
      $display("FAIL abort: busy=%b we=%b wd=%h, want 0/0/0", busy, reg_write, write_data);
    end
    writes = 0;
    for (int i = 0; i < LATENCY + 8; i++) begin
      @(negedge clk);
      if (reg_write === 1'b1) writes++;
    end
    total++;
    if (writes != 0) begin
      bad++;
      $display("FAIL abort_no_write: reg_write seen %0d times, want 0", writes);
    end
    do_op(2'b10, 32'd9, 32'd3, 3'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; dest_reg = '0;
    @(negedge clk);
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_dest_zero();
    test_back_to_back();
    test_ignored_start();
    test_reset_midcalc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
